// File: rtl/fuzz_capture_pkg.sv
// Shared types and MISR arithmetic for the fuzz response capture stage.
package fuzz_capture_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // The MISR arithmetic is defined for a 32-bit register.
   localparam int          MISR_W    = 32;
   localparam logic [31:0] MISR_POLY = 32'h04C1_1DB7;
   localparam logic [31:0] MISR_SEED = 32'hFFFF_FFFF;

   // One MISR step: Galois shift with feedback on the outgoing MSB, then
   // fold in the (already zero-extended) sample.
   function automatic logic [MISR_W-1:0] misr_step(input logic [MISR_W-1:0] sig,
                                                   input logic [MISR_W-1:0] data);
      logic [MISR_W-1:0] w_shift;
      w_shift   = {sig[MISR_W-2:0], 1'b0} ^ (sig[MISR_W-1] ? MISR_POLY : '0);
      misr_step = w_shift ^ data;
   endfunction

endpackage

// File: rtl/fuzz_misr.sv
// Signature register for the capture stage: reseeds on i_load_seed and
// compacts one sample per i_step. i_load_seed has priority over i_step.
module fuzz_misr
   import fuzz_capture_pkg::*;
#(
   parameter int SIG_W = 32,
   parameter int OUT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load_seed,
   input  logic             i_step,
   input  logic [OUT_W-1:0] i_data,
   output logic [SIG_W-1:0] o_sig
);

   logic [SIG_W-1:0] r_sig;
   logic [SIG_W-1:0] w_data_ext;

   assign w_data_ext = SIG_W'(i_data);

   // Signature register: seed on reset or run start, otherwise step on accept.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sig <= MISR_SEED;
      end else if (i_load_seed) begin
         r_sig <= MISR_SEED;
      end else if (i_step) begin
         r_sig <= misr_step(r_sig, w_data_ext);
      end
   end

   assign o_sig = r_sig;

endmodule

// File: rtl/fuzz_response_capture.sv
// Capture stage for the fuzz wrapper: compacts a run of response samples into
// a MISR signature, counts accepts and aborts when the input stalls.
// Optional per-bit toggle coverage is built when FUZZ_CAPTURE_COVERAGE_EN is
// defined; otherwise toggle_mask is tied to zero.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_IDLE | after reset, waiting for start
//   ST_RUN  | accepting samples, idle timer running
//   ST_DONE | run finished (count reached or stall); results held
module fuzz_response_capture
   import fuzz_capture_pkg::*;
#(
   parameter int OUT_W   = 8,
   parameter int SIG_W   = 32,
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] num_vectors,
   input  logic             in_valid,
   input  logic [OUT_W-1:0] in_data,
   output logic             in_ready,
   output logic             busy,
   output logic             done,
   output logic             timeout,
   output logic [SIG_W-1:0] signature,
   output logic [CNT_W-1:0] vec_count,
   output logic [OUT_W-1:0] toggle_mask
);

   localparam int IDLE_W = $clog2(TIMEOUT + 1);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [CNT_W-1:0]  r_num_vec;
   logic [CNT_W-1:0]  r_vec_cnt;
   logic [CNT_W-1:0]  w_cnt_nxt;
   logic [IDLE_W-1:0] r_idle_left;
   logic              r_busy;
   logic              r_done;
   logic              r_timeout;
   logic              w_in_ready;
   logic              w_accept;
   logic              w_last;
   logic              w_stall_tc;
   logic              w_load_seed;
   logic              w_step;
   logic              w_set_timeout;

   assign w_in_ready = (r_state == ST_RUN);
   assign w_accept   = in_valid & w_in_ready;
   assign w_cnt_nxt  = (&r_vec_cnt) ? r_vec_cnt : r_vec_cnt + 1'b1;
   assign w_last     = w_accept && (w_cnt_nxt == r_num_vec);
   // Terminal count: this idle cycle is the TIMEOUT-th in a row.
   assign w_stall_tc = w_in_ready && !w_accept && (r_idle_left == IDLE_W'(1));

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and control decode; a final accept beats a coincident stall.
   always_comb begin
      w_state_nxt   = r_state;
      w_load_seed   = 1'b0;
      w_step        = 1'b0;
      w_set_timeout = 1'b0;
      case (r_state)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               w_load_seed = 1'b1;
               w_state_nxt = (num_vectors == '0) ? ST_DONE : ST_RUN;
            end
         end
         ST_RUN: begin
            if (w_accept) begin
               w_step = 1'b1;
               if (w_last) begin
                  w_state_nxt = ST_DONE;
               end
            end else if (w_stall_tc) begin
               w_state_nxt   = ST_DONE;
               w_set_timeout = 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Run length, sample counter and idle down-counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_num_vec   <= '0;
         r_vec_cnt   <= '0;
         r_idle_left <= IDLE_W'(TIMEOUT);
      end else if (w_load_seed) begin
         r_num_vec   <= num_vectors;
         r_vec_cnt   <= '0;
         r_idle_left <= IDLE_W'(TIMEOUT);
      end else if (w_step) begin
         r_vec_cnt   <= w_cnt_nxt;
         r_idle_left <= IDLE_W'(TIMEOUT);
      end else if (w_in_ready && (r_idle_left != '0)) begin
         r_idle_left <= r_idle_left - 1'b1;
      end
   end

   // Registered status flags, loaded from the next state so they track it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         r_busy <= (w_state_nxt == ST_RUN);
         r_done <= (w_state_nxt == ST_DONE);
         if (w_load_seed) begin
            r_timeout <= 1'b0;
         end else if (w_set_timeout) begin
            r_timeout <= 1'b1;
         end
      end
   end

   fuzz_misr #(
      .SIG_W (SIG_W),
      .OUT_W (OUT_W)
   ) u_misr (
      .clk         (clk),
      .rst         (rst),
      .i_load_seed (w_load_seed),
      .i_step      (w_step),
      .i_data      (in_data),
      .o_sig       (signature)
   );

`ifdef FUZZ_CAPTURE_COVERAGE_EN
   logic [OUT_W-1:0] r_prev;
   logic [OUT_W-1:0] r_toggle;

   // Toggle coverage: the first accept of a run (count still zero) only
   // primes the previous-sample register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_prev   <= '0;
         r_toggle <= '0;
      end else if (w_load_seed) begin
         r_toggle <= '0;
      end else if (w_step) begin
         r_prev <= in_data;
         if (r_vec_cnt != '0) begin
            r_toggle <= r_toggle | (in_data ^ r_prev);
         end
      end
   end

   assign toggle_mask = r_toggle;
`else
   assign toggle_mask = '0;
`endif

   assign in_ready  = w_in_ready;
   assign busy      = r_busy;
   assign done      = r_done;
   assign timeout   = r_timeout;
   assign vec_count = r_vec_cnt;

endmodule

// File: tb/tb_fuzz_response_capture.sv
module tb_fuzz_response_capture;

   localparam int OUT_W   = 8;
   localparam int SIG_W   = 32;
   localparam int CNT_W   = 16;
   localparam int TIMEOUT = 255;
   localparam logic [31:0] SEED = 32'hFFFF_FFFF;
`ifdef FUZZ_CAPTURE_COVERAGE_EN
   localparam bit COV = 1'b1;
`else
   localparam bit COV = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [CNT_W-1:0] num_vectors;
   logic             in_valid;
   logic [OUT_W-1:0] in_data;
   logic             in_ready;
   logic             busy;
   logic             done;
   logic             timeout;
   logic [SIG_W-1:0] signature;
   logic [CNT_W-1:0] vec_count;
   logic [OUT_W-1:0] toggle_mask;

   fuzz_response_capture #(
      .OUT_W   (OUT_W),
      .SIG_W   (SIG_W),
      .CNT_W   (CNT_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .num_vectors (num_vectors),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_ready    (in_ready),
      .busy        (busy),
      .done        (done),
      .timeout     (timeout),
      .signature   (signature),
      .vec_count   (vec_count),
      .toggle_mask (toggle_mask)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] sig;
      logic [15:0] cnt;
      logic        to;
      logic [7:0]  mask;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   function automatic logic [31:0] model(input logic [31:0] s, input logic [7:0] d);
      return ({s[30:0], 1'b0} ^ (s[31] ? 32'h04C1_1DB7 : 32'h0)) ^ {24'h0, d};
   endfunction

   // Monitor: every rising edge of done is a result; compare it against the
   // oldest expectation queued by the stimulus.
   logic prev_done;
   exp_t e_mon;
   always @(negedge clk or posedge rst) begin
      if (rst) begin
         prev_done = 1'b0;
      end else begin
         if (done && !prev_done) begin
            if (exp_q.size() == 0) begin
               check("unexpected_done", 32'd1, 32'd0);
            end else begin
               e_mon = exp_q.pop_front();
               check("mon_signature", signature, e_mon.sig);
               check("mon_vec_count", 32'(vec_count), 32'(e_mon.cnt));
               check("mon_timeout", 32'(timeout), 32'(e_mon.to));
               check("mon_toggle_mask", 32'(toggle_mask), 32'(e_mon.mask));
            end
         end
         prev_done = done;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_run(input logic [15:0] n);
      start       = 1'b1;
      num_vectors = n;
      tick();
      start = 1'b0;
   endtask

   task automatic push_exp(input logic [31:0] s, input logic [15:0] c,
                           input logic t, input logic [7:0] m);
      exp_t e;
      e.sig  = s;
      e.cnt  = c;
      e.to   = t;
      e.mask = m;
      exp_q.push_back(e);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] e4;
      logic [31:0] e5;
      int          idle;

      rst = 1'b1;
      start = 1'b0;
      num_vectors = '0;
      in_valid = 1'b0;
      in_data = '0;
      tick();
      tick();
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_timeout", 32'(timeout), 32'd0);
      check("rst_signature", signature, SEED);
      check("rst_vec_count", 32'(vec_count), 32'd0);
      check("rst_toggle_mask", 32'(toggle_mask), 32'd0);
      rst = 1'b0;
      tick();

      // One zero sample.
      push_exp(32'hFB3E_E249, 16'd1, 1'b0, 8'h00);
      start_run(16'd1);
      check("t1_busy", 32'(busy), 32'd1);
      check("t1_in_ready", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_data  = 8'h00;
      tick();
      in_valid = 1'b0;
      check("t1_done_latency", 32'(done), 32'd1);
      tick();

      // One sample A5, restarted from DONE.
      push_exp(32'hFB3E_E2EC, 16'd1, 1'b0, 8'h00);
      start_run(16'd1);
      in_valid = 1'b1;
      in_data  = 8'hA5;
      tick();
      in_valid = 1'b0;
      tick();

      // Four samples with valid on every other cycle; extras dropped in DONE.
      e4 = model(model(model(model(SEED, 8'h11), 8'h22), 8'h33), 8'h44);
      push_exp(e4, 16'd4, 1'b0, COV ? 8'h77 : 8'h00);
      start_run(16'd4);
      for (int i = 0; i < 12; i++) begin
         in_valid = (i % 2 == 0);
         in_data  = 8'(8'h11 * (i / 2 + 1));
         tick();
      end
      in_valid = 1'b0;
      check("t3_done", 32'(done), 32'd1);
      check("t3_in_ready_done", 32'(in_ready), 32'd0);
      check("t3_vec_count", 32'(vec_count), 32'd4);
      check("t3_signature_held", signature, e4);

      // One accept then a stall: timeout after exactly TIMEOUT idle cycles.
      push_exp(model(SEED, 8'h5A), 16'd1, 1'b1, 8'h00);
      start_run(16'd3);
      in_valid = 1'b1;
      in_data  = 8'h5A;
      tick();
      in_valid = 1'b0;
      idle = 0;
      while (!done && idle < 300) begin
         tick();
         idle++;
      end
      check("t4_idle_cycles", 32'(idle), 32'(TIMEOUT));
      check("t4_busy", 32'(busy), 32'd0);

      // Toggle coverage: 0F then 3C.
      e5 = model(model(SEED, 8'h0F), 8'h3C);
      push_exp(e5, 16'd2, 1'b0, COV ? 8'h33 : 8'h00);
      start_run(16'd2);
      in_valid = 1'b1;
      in_data  = 8'h0F;
      tick();
      in_data  = 8'h3C;
      tick();
      in_valid = 1'b0;
      tick();

      // Reset mid-run, then an empty run.
      start_run(16'd5);
      in_valid = 1'b1;
      in_data  = 8'h77;
      tick();
      tick();
      #2 rst = 1'b1;
      #1;
      check("rst_mid_signature", signature, SEED);
      check("rst_mid_vec_count", 32'(vec_count), 32'd0);
      check("rst_mid_busy", 32'(busy), 32'd0);
      check("rst_mid_in_ready", 32'(in_ready), 32'd0);
      in_valid = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      push_exp(SEED, 16'd0, 1'b0, 8'h00);
      start_run(16'd0);
      check("t6_done", 32'(done), 32'd1);
      check("t6_busy", 32'(busy), 32'd0);
      tick();
      tick();

      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
